pdep_unit: RTL and testbench

- 8-bit parallel bit deposit (PDEP), the inverse of the team's combinational PEXT block: the low popcount(mask) bits of the data are scattered, in order, into the set bit positions of the mask.
- Multi-cycle engine built from a 3-stage butterfly network (stages swap at distances 4, 2, 1; the PEXT inverse-butterfly runs 1, 2, 4).
- Single-entry unit with valid/ready on both sides; sits beside the PEXT block in the SAG datapath.

---
 rtl/pdep_unit.sv | 177 +++++++++++++++++
 tb/tb_pdep_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdep_unit.sv
`default_nettype none
// ============================================================================
// Module   : pdep_unit
// Brief    : 8-bit parallel bit deposit (PDEP) on a multi-cycle 4/2/1
//            butterfly network with valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module pdep_unit #(
    parameter int STAGES_PER_CYCLE = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic [7:0] in_mask,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       busy
);

    localparam logic [1:0] C_LAST_CNT = 2'(3 / STAGES_PER_CYCLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DEC  = 2'd1,
        ST_BFLY = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [7:0]      r_data;
    logic [7:0]      r_mask;
    logic [7:0]      r_work;
    logic [7:0]      r_out;
    logic [2:0][3:0] r_ctl;
    logic [2:0][3:0] w_ctl;
    logic [1:0]      r_cnt;
    logic [7:0]      w_net;
    logic            w_accept;
    logic [2:0]      w_sum [0:6];

    // One butterfly stage: st 0/1/2 selects pair distance 4/2/1; c=1 passes.
    function automatic logic [7:0] bfly_stage(input logic [7:0] w,
                                              input logic [1:0] st,
                                              input logic [3:0] c);
        logic [7:0] r;
        logic [2:0] lo;
        logic [2:0] hi;
        r = w;
        for (int k = 0; k < 4; k++) begin
            case (st)
                2'd0: begin
                    lo = 3'(k);
                    hi = 3'(k + 4);
                end
                2'd1: begin
                    lo = 3'((k / 2) * 4 + (k % 2));
                    hi = lo + 3'd2;
                end
                default: begin
                    lo = 3'(2 * k);
                    hi = lo + 3'd1;
                end
            endcase
            if (!c[k]) begin
                r[lo] = w[hi];
                r[hi] = w[lo];
            end
        end
        return r;
    endfunction

    // Lane passes when it lies in [sum-d, sum) modulo 2d, i.e. bit log2(d) of (lane - sum).
    function automatic logic ctl_bit(input logic [2:0] lane,
                                     input logic [2:0] sum,
                                     input logic [1:0] sel);
        logic [2:0] diff;
        diff = lane - sum;
        return diff[sel];
    endfunction

    assign w_accept  = in_valid && in_ready;
    assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign out_data  = r_out;

    always_comb begin
        logic [2:0] acc;
        acc = 3'd0;
        for (int i = 0; i < 7; i++) begin
            acc      = acc + {2'b00, r_mask[i]};
            w_sum[i] = acc;
        end
    end

    always_comb begin
        w_ctl = '0;
        for (int l = 0; l < 4; l++) begin
            w_ctl[0][l] = ctl_bit(3'(l), w_sum[3], 2'd2);
        end
        for (int l = 0; l < 2; l++) begin
            w_ctl[1][l]     = ctl_bit(3'(l), w_sum[1], 2'd1);
            w_ctl[1][l + 2] = ctl_bit(3'(l), w_sum[5], 2'd1);
        end
        for (int l = 0; l < 4; l++) begin
            w_ctl[2][l] = ctl_bit(3'd0, w_sum[2 * l], 2'd0);
        end
    end

    generate
        if (STAGES_PER_CYCLE == 1) begin : g_serial
            logic [3:0] w_sel;
            always_comb begin
                case (r_cnt)
                    2'd0:    w_sel = r_ctl[0];
                    2'd1:    w_sel = r_ctl[1];
                    default: w_sel = r_ctl[2];
                endcase
            end
            assign w_net = bfly_stage(r_work, r_cnt, w_sel);
        end else if (STAGES_PER_CYCLE == 3) begin : g_parallel
            assign w_net = bfly_stage(bfly_stage(bfly_stage(r_work, 2'd0, r_ctl[0]),
                                                 2'd1, r_ctl[1]),
                                      2'd2, r_ctl[2]);
        end else begin : g_bad_param
            $error("pdep_unit: STAGES_PER_CYCLE must be 1 or 3");
        end
    endgenerate

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_DEC;
            ST_DEC:  w_next = ST_BFLY;
            ST_BFLY: if (r_cnt == C_LAST_CNT) w_next = ST_DONE;
            ST_DONE: if (out_ready) w_next = in_valid ? ST_DEC : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_mask  <= '0;
            r_work  <= '0;
            r_out   <= '0;
            r_ctl   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_data <= in_data;
                r_mask <= in_mask;
            end
            case (r_state)
                ST_DEC: begin
                    r_ctl  <= w_ctl;
                    r_work <= r_data;
                    r_cnt  <= 2'd0;
                end
                ST_BFLY: begin
                    r_work <= w_net;
                    r_cnt  <= r_cnt + 2'd1;
                    if (r_cnt == C_LAST_CNT) r_out <= w_net & r_mask;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pdep_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pdep_unit
// Brief    : Scoreboard bench for pdep_unit, one instance per legal stage count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pdep_unit;

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] m;
        logic [7:0] exp;
    } sb_t;

    logic       clk;
    logic       resetn;
    logic       iv   [2];
    logic       ir   [2];
    logic [7:0] id   [2];
    logic [7:0] im   [2];
    logic       ov   [2];
    logic       ordy [2];
    logic [7:0] od   [2];
    logic       bsy  [2];

    sb_t        sbq [$];
    logic [7:0] req_exp;
    int         n_assert;
    int         n_fail;
    int         cyc;
    int         t_acc   [2];
    int         n_acc   [2];
    logic       prev_ov [2];

    pdep_unit #(.STAGES_PER_CYCLE(1)) u_dut_s1 (
        .clk(clk), .resetn(resetn),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]), .in_mask(im[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .busy(bsy[0])
    );

    pdep_unit #(.STAGES_PER_CYCLE(3)) u_dut_s3 (
        .clk(clk), .resetn(resetn),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]), .in_mask(im[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .busy(bsy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pdep_ref(input logic [7:0] d, input logic [7:0] m);
        logic [7:0] r;
        int k;
        r = '0;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                r[i] = d[k];
                k++;
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] pext_ref(input logic [7:0] v, input logic [7:0] m);
        logic [7:0] r;
        int k;
        r = '0;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                r[k] = v[i];
                k++;
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] low_ones(input logic [7:0] m);
        int pc;
        pc = $countones(m);
        return 8'((1 << pc) - 1);
    endfunction

    function automatic int lat_of(input int u);
        int spc;
        spc = (u == 0) ? 1 : 3;
        return 2 + 3 / spc;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of unit u: called at posedge+1 with inputs already driven.
    task automatic tick(input int u);
        logic acc;
        logic hand;
        sb_t  e;
        #1;
        acc  = iv[u] && ir[u];
        hand = ov[u] && ordy[u];
        if (ov[u] && !prev_ov[u]) check("latency", cyc - t_acc[u], lat_of(u));
        prev_ov[u] = ov[u];
        if (hand) begin
            check("output_expected", int'(sbq.size() != 0), 1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                check("out_data", int'(od[u]), int'(e.exp));
                check("pext_inverse", int'(pext_ref(od[u], e.m)), int'(e.d & low_ones(e.m)));
            end
        end
        if (acc) begin
            sbq.push_back('{d: id[u], m: im[u], exp: req_exp});
            t_acc[u] = cyc;
            n_acc[u]++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input int u, input logic [7:0] d, input logic [7:0] m,
                         input logic [7:0] exp, input bit stall);
        int start;
        int guard;
        iv[u]   = 1'b1;
        id[u]   = d;
        im[u]   = m;
        req_exp = exp;
        ordy[u] = 1'b1;
        start   = n_acc[u];
        guard   = 0;
        while (n_acc[u] == start && guard < 50) begin
            tick(u);
            guard++;
        end
        if (n_acc[u] == start) check("accept_timeout", n_acc[u] - start, 1);
        iv[u] = 1'b0;
        id[u] = 8'($urandom_range(0, 255));
        im[u] = 8'($urandom_range(0, 255));
        guard = 0;
        while (sbq.size() != 0 && guard < 200) begin
            ordy[u] = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            tick(u);
            guard++;
        end
        if (sbq.size() != 0) check("result_timeout", sbq.size(), 0);
        ordy[u] = 1'b1;
    endtask

    initial begin
        int   start;
        int   guard;
        logic [7:0] d;
        n_assert = 0;
        n_fail   = 0;
        for (int u = 0; u < 2; u++) begin
            iv[u] = 1'b0; id[u] = '0; im[u] = '0; ordy[u] = 1'b1;
            t_acc[u] = 0; n_acc[u] = 0; prev_ov[u] = 1'b0;
        end
        req_exp = '0;
        resetn  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        for (int u = 0; u < 2; u++) begin
            check("rst_out_valid", int'(ov[u]), 0);
            check("rst_busy", int'(bsy[u]), 0);
            check("rst_out_data", int'(od[u]), 0);
            check("rst_in_ready", int'(ir[u]), 1);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Basic and sparse deposits, both stage counts.
        do_op(0, 8'h0B, 8'hF0, 8'hB0, 1'b0);
        do_op(0, 8'h0F, 8'hAA, 8'hAA, 1'b0);
        do_op(0, 8'h05, 8'hAA, 8'h22, 1'b0);
        do_op(0, 8'h02, 8'h81, 8'h80, 1'b0);
        do_op(1, 8'h0F, 8'hAA, 8'hAA, 1'b0);
        do_op(1, 8'h05, 8'hAA, 8'h22, 1'b0);
        do_op(1, 8'h02, 8'h81, 8'h80, 1'b0);

        // Extremes.
        do_op(0, 8'hFF, 8'h00, 8'h00, 1'b0);
        do_op(0, 8'h5A, 8'hFF, 8'h5A, 1'b0);
        do_op(0, 8'hFE, 8'h01, 8'h00, 1'b0);
        do_op(1, 8'h5A, 8'hFF, 8'h5A, 1'b0);

        // Backpressure with a queued request, then back-to-back handoff.
        ordy[0] = 1'b0;
        iv[0] = 1'b1; id[0] = 8'hC6; im[0] = 8'h5A; req_exp = 8'h18;
        start = n_acc[0];
        tick(0);
        check("bp_accept", n_acc[0] - start, 1);
        iv[0] = 1'b1; id[0] = 8'h03; im[0] = 8'h0F; req_exp = 8'h03;
        guard = 0;
        while (!ov[0] && guard < 20) begin
            tick(0);
            guard++;
        end
        check("bp_out_valid", int'(ov[0]), 1);
        for (int i = 0; i < 10; i++) begin
            check("bp_hold_data", int'(od[0]), 8'h18);
            check("bp_in_ready", int'(ir[0]), 0);
            check("bp_hold_valid", int'(ov[0]), 1);
            tick(0);
        end
        ordy[0] = 1'b1;
        #1;
        check("b2b_in_ready", int'(ir[0]), 1);
        start = n_acc[0];
        tick(0);
        check("b2b_accept", n_acc[0] - start, 1);
        iv[0] = 1'b0; id[0] = 8'hFF; im[0] = 8'hFF;
        guard = 0;
        while (sbq.size() != 0 && guard < 50) begin
            tick(0);
            guard++;
        end
        check("b2b_drain", sbq.size(), 0);

        // Asynchronous reset while the network is running.
        iv[0] = 1'b1; id[0] = 8'h77; im[0] = 8'hFF; req_exp = 8'h77;
        tick(0);
        iv[0] = 1'b0; id[0] = 8'h00; im[0] = 8'h00;
        tick(0);
        check("mid_busy", int'(bsy[0]), 1);
        resetn = 1'b0;
        #1;
        check("mid_rst_out_valid", int'(ov[0]), 0);
        check("mid_rst_busy", int'(bsy[0]), 0);
        check("mid_rst_out_data", int'(od[0]), 0);
        check("mid_rst_in_ready", int'(ir[0]), 1);
        sbq.delete();
        prev_ov[0] = 1'b0;
        prev_ov[1] = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        do_op(0, 8'h05, 8'h3C, 8'h14, 1'b0);

        // Every mask, random data and random output stalls.
        for (int m = 0; m < 256; m++) begin
            d = 8'($urandom_range(0, 255));
            do_op(0, d, 8'(m), pdep_ref(d, 8'(m)), 1'b1);
            for (int j = 0; j < 4; j++) begin
                d = 8'($urandom_range(0, 255));
                do_op(1, d, 8'(m), pdep_ref(d, 8'(m)), 1'b1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
